// File: rtl/fifo_ctrl_gen.sv
// Command-driven FIFO controller bridging a UART byte stream and an SD card
// reader/writer through one shared FIFO.
module fifo_ctrl_gen #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               cmd,
    input  logic                     cmd_valid,
    input  logic [CNT_W-1:0]         len,
    input  logic                     abort,
    input  logic [DATA_W-1:0]        rx_data,
    input  logic                     rx_valid,
    output logic [DATA_W-1:0]        tx_data,
    output logic                     tx_start,
    input  logic                     tx_done,
    output logic                     sd_init,
    input  logic                     init_ok,
    output logic                     sd_ren,
    input  logic [DATA_W-1:0]        sd_wdata,
    input  logic                     sd_wvalid,
    input  logic                     sd_read_ok,
    output logic                     sd_wen,
    output logic [DATA_W-1:0]        sd_rdata,
    input  logic                     sd_rpop,
    input  logic                     sd_write_ok,
    input  logic                     fe_done,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        RX_FILL,
        TX_DRAIN,
        SD_INIT,
        SD_READ,
        SD_WRITE,
        DONE
    } state_t;

    state_t state, state_d;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       count;
    logic [CNT_W-1:0]  cnt;
    logic              in_flight;

    logic              push_req, pop_req, push_ok, pop_ok, drop;
    logic [DATA_W-1:0] push_data;
    logic              flush, load_cnt, dec_cnt, accept;
    logic              issue, clear_flight;
    logic              sd_init_d, sd_ren_d, sd_wen_d;
    logic              empty, full;

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));

    // A full FIFO still accepts a push when a pop frees a slot in the same cycle
    assign pop_ok  = pop_req & ~empty;
    assign push_ok = push_req & (~full | pop_ok);
    assign drop    = push_req & ~push_ok;

    assign sd_rdata = mem[rd_ptr];
    assign level    = count;
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

    always_comb begin
        state_d      = state;
        push_req     = 1'b0;
        pop_req      = 1'b0;
        push_data    = rx_data;
        flush        = 1'b0;
        load_cnt     = 1'b0;
        dec_cnt      = 1'b0;
        accept       = 1'b0;
        issue        = 1'b0;
        clear_flight = 1'b0;
        sd_init_d    = sd_init;
        sd_ren_d     = sd_ren;
        sd_wen_d     = sd_wen;
        if (abort) begin
            state_d   = IDLE;
            flush     = 1'b1;
            sd_init_d = 1'b0;
            sd_ren_d  = 1'b0;
            sd_wen_d  = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        unique case (1'b1)
                            (cmd == 8'h01): begin
                                state_d  = RX_FILL;
                                load_cnt = 1'b1;
                                accept   = 1'b1;
                            end
                            (cmd == 8'h02): begin
                                state_d  = SD_INIT;
                                load_cnt = 1'b1;
                                accept   = 1'b1;
                            end
                            (cmd == 8'h03): begin
                                state_d  = SD_READ;
                                sd_ren_d = 1'b1;
                                accept   = 1'b1;
                            end
                            (cmd == 8'h04): begin
                                state_d  = SD_WRITE;
                                sd_wen_d = 1'b1;
                                accept   = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                RX_FILL: begin
                    if (cnt == '0) begin
                        state_d = TX_DRAIN;
                    end else if (rx_valid) begin
                        push_req = 1'b1;
                        dec_cnt  = 1'b1;
                    end
                end
                TX_DRAIN: begin
                    if (in_flight) begin
                        clear_flight = tx_done;
                    end else if (!empty) begin
                        pop_req = 1'b1;
                        issue   = 1'b1;
                    end else begin
                        state_d = DONE;
                    end
                end
                SD_INIT: begin
                    // Preamble bytes are counted off and discarded
                    if (cnt != '0) begin
                        sd_init_d = 1'b0;
                        dec_cnt   = rx_valid;
                    end else if (init_ok) begin
                        sd_init_d = 1'b0;
                        state_d   = DONE;
                    end else begin
                        sd_init_d = 1'b1;
                    end
                end
                SD_READ: begin
                    push_req  = sd_wvalid;
                    push_data = sd_wdata;
                    if (sd_read_ok) begin
                        sd_ren_d = 1'b0;
                        state_d  = TX_DRAIN;
                    end
                end
                SD_WRITE: begin
                    // UART bytes feed the SD writer through the FIFO
                    push_req = rx_valid;
                    pop_req  = sd_rpop;
                    if (sd_write_ok) begin
                        sd_wen_d = 1'b0;
                        state_d  = DONE;
                    end
                end
                DONE: begin
                    if (fe_done) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            tx_start  <= 1'b0;
            tx_data   <= '0;
            sd_init   <= 1'b0;
            sd_ren    <= 1'b0;
            sd_wen    <= 1'b0;
            in_flight <= 1'b0;
        end else begin
            sd_init  <= sd_init_d;
            sd_ren   <= sd_ren_d;
            sd_wen   <= sd_wen_d;
            tx_start <= issue;
            if (issue) tx_data <= mem[rd_ptr];
            if (flush) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                count     <= '0;
                cnt       <= '0;
                in_flight <= 1'b0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + AW'(1);
                if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
                count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
                if (issue)             in_flight <= 1'b1;
                else if (clear_flight) in_flight <= 1'b0;
                if (load_cnt)     cnt <= len;
                else if (dec_cnt) cnt <= cnt - CNT_W'(1);
            end
            if (accept)    ovf <= 1'b0;
            else if (drop) ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: doc/fifo_ctrl_gen.md
FIFO_CTRL_GEN -- requirements
Module: fifo_ctrl_gen

Interface
REQ-001 SHALL have parameter DATA_W, default 8, byte/word width of all data paths.
REQ-002 SHALL have parameter DEPTH, default 16, FIFO entries; power of two, >=2.
REQ-003 SHALL have parameter CNT_W, default 16, width of transfer length.
REQ-004 SHALL have ports as listed, one clock; reset is synchronous and active-high:
 clk  in  1  system clock; all logic on rising edge
 rst  in  1  synchronous active-high reset
 cmd  in  8  command code, sampled when cmd_valid=1
 cmd_valid  in  1  command strobe
 len  in  CNT_W  byte count for cmd 01/02, sampled with cmd
 abort  in  1  return to IDLE, flush FIFO
 rx_data  in  DATA_W  received UART byte
 rx_valid  in  1  one-cycle strobe per received byte
 tx_data  out  DATA_W  byte to UART transmitter, held from tx_start until tx_done
 tx_start  out  1  one-cycle transmit request
 tx_done  in  1  one-cycle strobe, transmitter finished byte
 sd_init  out  1  SD init request
 init_ok  in  1  SD init complete
 sd_ren  out  1  SD read request
 sd_wdata  in  DATA_W  byte from SD reader
 sd_wvalid  in  1  strobe, push sd_wdata
 sd_read_ok  in  1  SD read complete
 sd_wen  out  1  SD write request
 sd_rdata  out  DATA_W  FIFO head, combinational
 sd_rpop  in  1  strobe, SD writer consumed sd_rdata
 sd_write_ok  in  1  SD write complete
 fe_done  in  1  host acknowledges completion
 busy  out  1  state != IDLE
 done  out  1  state == DONE
 level  out  clog2(DEPTH)+1  FIFO occupancy
 ovf  out  1  sticky overflow flag

Function
REQ-005 SHALL implement states IDLE, RX_FILL, TX_DRAIN, SD_INIT, SD_READ, SD_WRITE, DONE.
REQ-006 IDLE: cmd_valid with cmd 01 -> RX_FILL, cnt<=len; 02 -> SD_INIT, cnt<=len; 03 -> SD_READ, sd_ren<=1; 04 -> SD_WRITE, sd_wen<=1; other codes ignored, stay IDLE.
REQ-007 cmd_valid outside IDLE SHALL be ignored; accepted command SHALL clear ovf.
REQ-008 RX_FILL: each rx_valid with cnt>0 pushes rx_data, cnt-=1; when cnt==0 -> TX_DRAIN next cycle; len=0 gives one RX_FILL cycle then TX_DRAIN.
REQ-009 TX_DRAIN: when no byte in flight and FIFO non-empty, pop head into tx_data and pulse tx_start one cycle; next byte only after tx_done; FIFO empty and none in flight -> DONE.
REQ-010 tx_done with no byte in flight SHALL be ignored.
REQ-011 SD_INIT: rx_valid bytes decrement cnt and are discarded (not pushed); while cnt>0 sd_init=0; at cnt==0 sd_init<=1 until init_ok, then sd_init<=0, -> DONE.
REQ-012 SD_READ: sd_wvalid pushes sd_wdata; sd_read_ok -> TX_DRAIN, sd_ren<=0; sd_wvalid coincident with sd_read_ok SHALL still be pushed.
REQ-013 SD_WRITE: sd_rpop pops when non-empty; sd_write_ok -> DONE, sd_wen<=0.
REQ-014 DONE: hold until fe_done, then -> IDLE; done=1 exactly while in DONE.
REQ-015 Push when level==DEPTH SHALL be dropped and set ovf; pop when empty SHALL be ignored, level unchanged.
REQ-016 Simultaneous push and pop SHALL both occur when FIFO non-empty and not full-blocked; level unchanged; on full, pop with push SHALL accept both.
REQ-017 Pointers SHALL wrap modulo DEPTH; level SHALL count 0..DEPTH inclusive.
REQ-018 abort in any state SHALL next cycle: state=IDLE, FIFO flushed (level=0), sd_init/sd_ren/sd_wen/tx_start=0, in-flight cleared; abort has priority over all other inputs; ovf retained.
REQ-019 All outputs except sd_rdata, busy, done, level SHALL be registered.

Reset
REQ-020 rst=1 at clk edge SHALL set state=IDLE, level=0, pointers=0, cnt=0, ovf=0, tx_start=0, tx_data=0, sd_init=0, sd_ren=0, sd_wen=0, in-flight=0; mid-operation reset behaves identically, FIFO contents discarded.

Verification
REQ-021 cmd=01,len=3; rx bytes A1,B2,C3 -> three tx_start pulses with tx_data A1,B2,C3 each after prior tx_done, then done=1; fe_done -> busy=0.
REQ-022 DEPTH=16, cmd=01,len=18, no tx during fill -> 16 bytes stored, ovf=1, level=16, first 16 bytes transmitted in order.
REQ-023 cmd=03; 5 sd_wvalid bytes, last coincident with sd_read_ok -> sd_ren falls, 5 bytes transmitted, DONE.
REQ-024 cmd=02,len=2; two rx bytes -> sd_init=1, level=0; init_ok -> sd_init=0, done=1.
REQ-025 cmd=04 after preloading 4 bytes; sd_rpop x4 plus x1 extra -> 4 bytes in order, level stays 0; sd_write_ok -> sd_wen=0, DONE.
REQ-026 abort during TX_DRAIN with byte in flight, then cmd=01 -> IDLE, level=0, ovf cleared by new command, next transfer correct; rst mid-RX_FILL -> all REQ-020 values.
